// File: rtl/ccip_host_wr_responder.sv
// Host-side CCI-P c1 write responder: answers each write with its mdata after a fixed latency.
// Optional capture RAM for write data enabled by defining CCIP_HOST_WR_CAPTURE_EN.
module ccip_host_wr_responder #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned ALM_FULL_SLACK = 8,
    parameter int unsigned RSP_LATENCY    = 4,
    parameter int unsigned CAP_ENTRIES    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           c1_tx_valid,
    input  logic [41:0]                    c1_tx_addr,
    input  logic [15:0]                    c1_tx_mdata,
    input  logic [511:0]                   c1_tx_data,
    output logic                           c1_tx_alm_full,
    output logic                           c1_rx_wr_rsp_valid,
    output logic [15:0]                    c1_rx_wr_rsp_mdata,
    output logic [31:0]                    wr_count,
    output logic                           overflow_err,
    input  logic [$clog2(CAP_ENTRIES)-1:0] cap_rd_idx,
    output logic [511:0]                   cap_rd_data
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned CAP_W  = $clog2(CAP_ENTRIES);
    localparam int unsigned ALM_TH = FIFO_DEPTH - ALM_FULL_SLACK;

    typedef struct packed {
        logic [15:0] mdata;
        logic [7:0]  ts;
    } entry_t;

    entry_t            fifo_mem [FIFO_DEPTH];
    entry_t            head;
    logic [7:0]        age;
    logic              deq;
    logic              full;
    logic              acc;

    logic [7:0]        now_q,       now_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic              alm_full_q,  alm_full_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_mdata_q, rsp_mdata_d;
    logic [31:0]       wr_count_q,  wr_count_d;
    logic              overflow_q,  overflow_d;

    // Release/accept decisions use registered occupancy, so a fresh entry is never released in its enqueue cycle.
    always_comb begin
        head        = fifo_mem[rd_ptr_q];
        age         = now_q - head.ts;
        deq         = (count_q != '0) && (age >= 8'(RSP_LATENCY));
        full        = (count_q == CNT_W'(FIFO_DEPTH));
        acc         = c1_tx_valid && (!full || deq);

        now_d       = now_q + 8'd1;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rsp_valid_d = deq;
        rsp_mdata_d = '0;
        wr_count_d  = wr_count_q + 32'(deq);
        overflow_d  = overflow_q | (c1_tx_valid && full && !deq);

        if (acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            rsp_mdata_d = head.mdata;
        end
        count_d    = count_q + CNT_W'(acc) - CNT_W'(deq);
        alm_full_d = (count_d >= CNT_W'(ALM_TH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            now_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alm_full_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_mdata_q <= '0;
            wr_count_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            now_q       <= now_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alm_full_q  <= alm_full_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_mdata_q <= rsp_mdata_d;
            wr_count_q  <= wr_count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Pending-response storage; stale contents are harmless because occupancy is reset.
    always_ff @(posedge clk) begin
        if (acc) begin
            fifo_mem[wr_ptr_q] <= '{mdata: c1_tx_mdata, ts: now_q};
        end
    end

    assign c1_tx_alm_full     = alm_full_q;
    assign c1_rx_wr_rsp_valid = rsp_valid_q;
    assign c1_rx_wr_rsp_mdata = rsp_mdata_q;
    assign wr_count           = wr_count_q;
    assign overflow_err       = overflow_q;

`ifdef CCIP_HOST_WR_CAPTURE_EN
    logic [511:0] cap_mem [CAP_ENTRIES];
    logic [511:0] cap_rd_data_q, cap_rd_data_d;
    logic         unused_cap;

    assign cap_rd_data_d = cap_mem[cap_rd_idx];

    // Read-before-write: a same-index read in the write cycle sees the old line.
    always_ff @(posedge clk) begin
        if (acc) begin
            cap_mem[c1_tx_addr[CAP_W-1:0]] <= c1_tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_rd_data_q <= '0;
        end else begin
            cap_rd_data_q <= cap_rd_data_d;
        end
    end

    assign cap_rd_data = cap_rd_data_q;
    assign unused_cap  = ^c1_tx_addr[41:CAP_W];
`else
    logic unused_cap;

    assign cap_rd_data = '0;
    assign unused_cap  = ^{cap_rd_idx, c1_tx_addr, c1_tx_data};
`endif

endmodule

// File: tb/tb_ccip_host_wr_responder.sv
// Directed bench for ccip_host_wr_responder: a default instance (latency 4) and a slow one (latency 40).
module tb_ccip_host_wr_responder;

    logic         clk = 1'b0;
    logic         reset;

    logic         v_a, v_b;
    logic [41:0]  addr_a, addr_b;
    logic [15:0]  md_a, md_b;
    logic [511:0] data_a, data_b;
    logic [2:0]   idx_a, idx_b;
    logic         alm_a, alm_b, rv_a, rv_b, ovf_a, ovf_b;
    logic [15:0]  rm_a, rm_b;
    logic [31:0]  cnt_a, cnt_b;
    logic [511:0] cap_a, cap_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ccip_host_wr_responder u_dut (
        .clk(clk), .reset(reset),
        .c1_tx_valid(v_a), .c1_tx_addr(addr_a), .c1_tx_mdata(md_a), .c1_tx_data(data_a),
        .c1_tx_alm_full(alm_a), .c1_rx_wr_rsp_valid(rv_a), .c1_rx_wr_rsp_mdata(rm_a),
        .wr_count(cnt_a), .overflow_err(ovf_a), .cap_rd_idx(idx_a), .cap_rd_data(cap_a)
    );

    ccip_host_wr_responder #(.RSP_LATENCY(40)) u_slow (
        .clk(clk), .reset(reset),
        .c1_tx_valid(v_b), .c1_tx_addr(addr_b), .c1_tx_mdata(md_b), .c1_tx_data(data_b),
        .c1_tx_alm_full(alm_b), .c1_rx_wr_rsp_valid(rv_b), .c1_rx_wr_rsp_mdata(rm_b),
        .wr_count(cnt_b), .overflow_err(ovf_b), .cap_rd_idx(idx_b), .cap_rd_data(cap_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        v_a = 1'b0; v_b = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int nrsp;
        logic [511:0] hello;
        reset  = 1'b1;
        v_a = 1'b0; addr_a = '0; md_a = '0; data_a = '0; idx_a = '0;
        v_b = 1'b0; addr_b = '0; md_b = '0; data_b = '0; idx_b = '0;
        step();
        step();

        // Reset state
        check("rst_rsp_valid", 512'(rv_a), 512'(0));
        check("rst_rsp_mdata", 512'(rm_a), 512'(0));
        check("rst_wr_count", 512'(cnt_a), 512'(0));
        check("rst_alm_full", 512'(alm_a), 512'(0));
        check("rst_overflow", 512'(ovf_a), 512'(0));
        check("rst_cap", cap_a, 512'(0));
        reset = 1'b0;
        step();

        // Single write: response exactly 5 cycles after the request cycle
        v_a = 1'b1; addr_a = 42'h10; md_a = 16'hBEEF;
        for (int k = 1; k <= 8; k++) begin
            step();
            v_a = 1'b0;
            check("single_rsp_valid", 512'(rv_a), 512'(k == 5));
            if (k == 5) check("single_rsp_mdata", 512'(rm_a), 512'(16'hBEEF));
        end
        check("single_wr_count", 512'(cnt_a), 512'(1));

        // 8 back-to-back writes: responses on 8 consecutive cycles, in order
        do_reset();
        for (int s = 0; s < 16; s++) begin
            v_a  = (s < 8);
            md_a = 16'(s);
            step();
            check("b2b_rsp_valid", 512'(rv_a), 512'(s >= 4 && s < 12));
            if (s >= 4 && s < 12) check("b2b_rsp_mdata", 512'(rm_a), 512'(s - 4));
            check("b2b_alm_full", 512'(alm_a), 512'(0));
        end
        v_a = 1'b0;
        check("b2b_wr_count", 512'(cnt_a), 512'(8));

        // 17 writes into the latency-40 instance: last one dropped, sticky overflow
        do_reset();
        for (int s = 0; s < 17; s++) begin
            v_b  = 1'b1;
            md_b = 16'(s);
            step();
            check("ovf_alm_full", 512'(alm_b), 512'(s + 1 >= 8));
            check("ovf_flag", 512'(ovf_b), 512'(s >= 16));
        end
        v_b  = 1'b0;
        nrsp = 0;
        for (int s = 17; s < 80; s++) begin
            step();
            if (rv_b) begin
                check("ovf_rsp_mdata", 512'(rm_b), 512'(nrsp));
                nrsp++;
            end
        end
        check("ovf_rsp_total", 512'(nrsp), 512'(16));
        check("ovf_wr_count", 512'(cnt_b), 512'(16));
        check("ovf_sticky", 512'(ovf_b), 512'(1));
        check("ovf_alm_after_drain", 512'(alm_b), 512'(0));

        // 300 continuous writes spanning several timestamp wraps
        do_reset();
        for (int s = 0; s < 310; s++) begin
            v_a  = (s < 300);
            md_a = 16'(s + 16'h1000);
            step();
            check("wrap_rsp_valid", 512'(rv_a), 512'(s >= 4 && s < 304));
            if (s >= 4 && s < 304) check("wrap_rsp_mdata", 512'(rm_a), 512'(s - 4 + 16'h1000));
        end
        v_a = 1'b0;
        check("wrap_wr_count", 512'(cnt_a), 512'(300));

        // Reset with responses pending: nothing comes out afterwards
        do_reset();
        for (int s = 0; s < 5; s++) begin
            v_a = 1'b1; md_a = 16'(s);
            v_b = 1'b1; md_b = 16'(s);
            step();
        end
        v_a = 1'b0; v_b = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 512'(rv_a), 512'(0));
        check("mid_rst_wr_count", 512'(cnt_a), 512'(0));
        check("mid_rst_slow_wr_count", 512'(cnt_b), 512'(0));
        step();
        check("mid_rst_rsp_mdata", 512'(rm_a), 512'(0));
        reset = 1'b0;
        nrsp = 0;
        for (int s = 0; s < 60; s++) begin
            step();
            if (rv_a || rv_b) nrsp++;
        end
        check("post_rst_no_rsp", 512'(nrsp), 512'(0));
        check("post_rst_wr_count", 512'(cnt_a), 512'(0));

        // Capture RAM: "Hello" written at index 3
        hello  = 512'h48656C6C6F;
        v_a    = 1'b1; addr_a = 42'h3; data_a = hello; md_a = 16'h0;
        step();
        v_a    = 1'b0; idx_a = 3'd3;
        step();
`ifdef CCIP_HOST_WR_CAPTURE_EN
        check("cap_rd_data", cap_a, hello);
`else
        check("cap_rd_data", cap_a, 512'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
